// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared FSM state type and byte/word geometry for the instruction memory loader
package instr_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs accepted bytes little-endian into a 32-bit word
// Ports: clk, rst_n (async active-low), byte_en (accept byte_in this cycle),
//        byte_in (stream byte), clear (restart at byte 0),
//        word_full (the byte being accepted completes the word), word_out (packed word)
module byte_word_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              clear,
  output logic              word_full,
  output logic [WORD_W-1:0] word_out
);
  logic [1:0] cnt;
  assign word_full = byte_en && cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      word_out <= '0;
    end else if (clear) begin
      cnt      <= '0;
      word_out <= '0;
    end else if (byte_en) begin
      word_out[BYTE_W*cnt +: BYTE_W] <= byte_in;
      cnt                            <= cnt + 2'd1;
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream loader that writes packed words to sequential instruction memory addresses
// Ports: clk, rst_n (async active-low), start/word_count (load request and length),
//        byte_valid/byte_data/byte_ready (byte stream handshake), we/waddr/wdata (memory write port),
//        busy, done, core_hold (processor held while loading), chk_err (checksum mismatch).
// Build option: define INSTR_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the image.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WORD_W-1:0]     wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  core_hold,
  output logic                  chk_err
);
  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam loader_state_t LAST = S_CHECK;
`else
  localparam loader_state_t LAST = S_DONE;
`endif
  loader_state_t       state;
  logic [ADDR_WIDTH:0] count, index, index_nx;
  logic                accept, start_ok, word_full;
  logic [WORD_W-1:0]   word;
  assign accept     = byte_valid && byte_ready;
  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign index_nx   = index + 1'b1;
  assign byte_ready = state == S_RECV || state == S_CHECK;
  assign we         = state == S_WRITE;
  assign waddr      = we ? index[ADDR_WIDTH-1:0] : '0;
  assign wdata      = we ? word : '0;
  assign busy       = state == S_RECV || state == S_WRITE || state == S_CHECK;
  assign done       = state == S_DONE;
  assign core_hold  = busy;
  byte_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_en  (accept && state == S_RECV),
    .byte_in  (byte_data),
    .clear    (start_ok),
    .word_full(word_full),
    .word_out (word)
  );
  // count saturates at capacity, so index never wraps past the top address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      index <= '0;
    end else case (state)
      S_IDLE, S_DONE: if (start) begin
        count <= word_count > CAP ? CAP : word_count;
        index <= '0;
        state <= word_count == '0 ? S_DONE : S_RECV;
      end
      S_RECV:  if (word_full) state <= S_WRITE;
      S_WRITE: begin
        index <= index_nx;
        state <= index_nx == count ? LAST : S_RECV;
      end
      S_CHECK: if (accept) state <= S_DONE;
      default: state <= S_IDLE;
    endcase
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  logic              chk_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      csum  <= '0;
      chk_r <= 1'b0;
    end else if (start_ok) begin
      csum  <= '0;
      chk_r <= 1'b0;
    end else if (accept && state == S_RECV) begin
      csum <= csum ^ byte_data;
    end else if (accept && state == S_CHECK) begin
      chk_r <= byte_data != csum;
    end
  assign chk_err = chk_r;
`else
  assign chk_err = 1'b0;
`endif
endmodule
